// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key map and geometry for the 4x4 keypad scanner
package keypad_pkg;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  typedef enum logic [0:0] {S_SCAN = 1'b0, S_EVAL = 1'b1} scan_state_t;
  typedef enum logic [0:0] {D_RELEASED = 1'b0, D_PRESSED = 1'b1} deb_state_t;
  typedef enum logic [1:0] {FC_NONE = 2'd0, FC_SINGLE = 2'd1, FC_MULTI = 2'd2} frame_class_t;
  // Indexed [row][col]; '*' and '#' map to 0xE and 0xF
  localparam logic [3:0] KEYMAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
endpackage

// File: rtl/keypad_frame_eval.sv
// keypad_frame_eval: classifies a 16-bit frame (bit c*4+r, active-low) into none/single/multi plus key code
module keypad_frame_eval
  import keypad_pkg::*;
(
  input  logic [15:0]  frame,
  output frame_class_t fclass,
  output logic [3:0]   code
);
  logic [4:0] lows;
  logic [3:0] idx;
  always_comb begin
    lows = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++)
      if (!frame[i]) begin
        lows = lows + 5'd1;
        idx  = 4'(i);
      end
    fclass = (lows == 5'd0) ? FC_NONE : (lows == 5'd1) ? FC_SINGLE : FC_MULTI;
    code   = KEYMAP[idx[1:0]][idx[3:2]];
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scanner with frame debounce and valid/ready key event output
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int DEB_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);
  localparam int PW = $clog2(SETTLE_CYC);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  logic [3:0]    row_m, row_s;
  scan_state_t   sst;
  logic [1:0]    col;
  logic [PW-1:0] phase;
  logic [15:0]   frame;
  deb_state_t    dst, dst_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    cand, cand_n, code;
  frame_class_t  fclass;
  logic          issue;
  assign Col      = ~(4'b0001 << col);
  assign key_held = (dst == D_PRESSED);
  keypad_frame_eval u_eval (.frame(frame), .fclass(fclass), .code(code));
  // Idle rows read high, so the synchronizer and frame clear to all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
      sst   <= S_SCAN;
      col   <= 2'd0;
      phase <= '0;
      frame <= 16'hFFFF;
    end else begin
      row_m <= Row;
      row_s <= row_m;
      if (sst == S_EVAL) sst <= S_SCAN;
      else if (phase == PW'(SETTLE_CYC - 1)) begin
        frame[{col, 2'b00} +: 4] <= row_s;
        phase <= '0;
        col   <= col + 2'd1;
        if (col == 2'd3) sst <= S_EVAL;
      end else phase <= phase + PW'(1);
    end
  end
  assign cnt_inc = (cnt == CW'(DEB_FRAMES)) ? cnt : cnt + CW'(1);
  always_comb begin
    dst_n  = dst;
    cnt_n  = cnt;
    cand_n = cand;
    issue  = 1'b0;
    if (sst == S_EVAL) begin
      if (dst == D_RELEASED) begin
        cnt_n  = (fclass == FC_SINGLE) ? ((code == cand) ? cnt_inc : CW'(1)) : '0;
        cand_n = (fclass == FC_SINGLE) ? code : cand;
        if (cnt_n == CW'(DEB_FRAMES)) begin
          dst_n = D_PRESSED;
          cnt_n = '0;
          issue = 1'b1;
        end
      end else begin
        cnt_n = (fclass == FC_NONE) ? cnt_inc : '0;
        if (cnt_n == CW'(DEB_FRAMES)) begin
          dst_n = D_RELEASED;
          cnt_n = '0;
        end
      end
    end
  end
  // A new press loads if the slot is empty or being drained this edge; otherwise it is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst       <= D_RELEASED;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dst  <= dst_n;
      cnt  <= cnt_n;
      cand <= cand_n;
      if (issue) begin
        if (!key_valid || key_ready) begin
          key_code  <= cand_n;
          key_valid <= 1'b1;
        end else overflow <= 1'b1;
      end else if (key_ready) key_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed keypad stimulus with a queue-based key event scoreboard
module tb_keypad_scan_ctrl;
  localparam int S  = 8;
  localparam int D  = 4;
  localparam int FR = 4 * S + 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  Row, Col, key_code;
  logic        key_valid, key_held, overflow;
  logic        key_ready = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  logic [3:0]  col_exp;
  int          checks = 0;
  int          failures = 0;

  keypad_scan_ctrl #(.SETTLE_CYC(S), .DEB_FRAMES(D)) dut (
    .clk(clk), .rst_n(rst_n), .Row(Row), .Col(Col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key at row r, column c is bit r*4+c; it pulls row r low while column c is driven
  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++) Row[r] = ~|(pressed[r*4 +: 4] & ~Col);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event: got unexpected key %h expected none", key_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_code !== mon_exp) begin
          failures++;
          $display("FAIL event: got key %h expected %h", key_code, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FR) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 key_ready = v;
  endtask

  // Returns at the negedge inside an EVAL cycle (Col just stepped 0111 -> 1110)
  task automatic sync_eval();
    logic [3:0] prev;
    prev = Col;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && Col == 4'b1110) return;
      prev = Col;
    end
    checks++;
    failures++;
    $display("FAIL sync: got no EVAL within %0d cycles expected one", 2 * FR);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_col", Col, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    // 1: single key 5, exact debounce timing on press and release
    set_ready(1'b1);
    sync_eval();
    pressed = 16'h0020;
    exp_q.push_back(4'h5);
    repeat (4 * FR) @(negedge clk);
    check("t1_held_pre", key_held, 0);
    @(negedge clk);
    check("t1_held_rise", key_held, 1);
    frames(15);
    sync_eval();
    pressed = '0;
    repeat (4 * FR) @(negedge clk);
    check("t1_held_hold", key_held, 1);
    @(negedge clk);
    check("t1_held_fall", key_held, 0);
    // 2: bouncing key E, then stable
    sync_eval();
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'h1000 : 16'h0000;
      sync_eval();
    end
    check("t2_bounce_held", key_held, 0);
    exp_q.push_back(4'hE);
    pressed = 16'h1000;
    repeat (4 * FR) @(negedge clk);
    check("t2_held_pre", key_held, 0);
    @(negedge clk);
    check("t2_held_rise", key_held, 1);
    pressed = '0;
    frames(6);
    check("t2_released", key_held, 0);
    // 3: two keys together, then drop one
    pressed = 16'h0801;
    frames(12);
    check("t3_multi_held", key_held, 0);
    check("t3_multi_valid", key_valid, 0);
    exp_q.push_back(4'h1);
    pressed = 16'h0001;
    frames(6);
    check("t3_single_held", key_held, 1);
    pressed = '0;
    frames(6);
    check("t3_released", key_held, 0);
    // 4: back-pressure and overflow
    set_ready(1'b0);
    pressed = 16'h0002;
    exp_q.push_back(4'h2);
    frames(6);
    pressed = '0;
    frames(6);
    check("t4_valid", key_valid, 1);
    check("t4_code", key_code, 4'h2);
    check("t4_ovf_pre", overflow, 0);
    pressed = 16'h0400;
    frames(6);
    check("t4_ovf", overflow, 1);
    check("t4_valid_hold", key_valid, 1);
    check("t4_code_hold", key_code, 4'h2);
    check("t4_held9", key_held, 1);
    pressed = '0;
    frames(6);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    check("t4_valid_drop", key_valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    // 5: reset while key 0 is held
    set_ready(1'b1);
    pressed = 16'h2000;
    exp_q.push_back(4'h0);
    frames(6);
    check("t5_held", key_held, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_col", Col, 4'b1110);
    check("t5_rst_valid", key_valid, 0);
    check("t5_rst_held", key_held, 0);
    check("t5_rst_ovf", overflow, 0);
    check("t5_rst_code", key_code, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'h0);
    frames(3);
    check("t5_redet_pre", key_held, 0);
    frames(2);
    check("t5_redet", key_held, 1);
    pressed = '0;
    frames(6);
    // 6: column sequence over one frame, then key D twice
    sync_eval();
    for (int k = 1; k <= FR; k++) begin
      @(negedge clk);
      col_exp = (k == FR) ? 4'b1110 : ~(4'b0001 << ((k - 1) / S));
      check("t6_col", Col, col_exp);
    end
    for (int n = 0; n < 2; n++) begin
      pressed = 16'h8000;
      exp_q.push_back(4'hD);
      frames(6);
      check("t6_held", key_held, 1);
      pressed = '0;
      frames(6);
      check("t6_released", key_held, 0);
    end
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
